tthbif_cfg_regs: RTL and testbench

//  UART-byte command parser and configuration register file for the tthbif lane.

---
 rtl/tthbif_pkg.sv | 41 ++++
 rtl/tthbif_cfg_regs.sv | 201 ++++++++++++++++++++
 tb/tb_tthbif_cfg_regs.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tthbif_pkg.sv
// tthbif_pkg
//   Shared definitions for the tthbif configuration register block:
//   register address map, command byte layout, fixed response bytes,
//   STATUS bit positions, FSM state encoding and the tap clamp helper.
package tthbif_pkg;

  typedef enum logic [3:0] {
    ADDR_RX_FLOP = 4'd0,
    ADDR_RX_COMB = 4'd1,
    ADDR_TX_FLOP = 4'd2,
    ADDR_TX_COMB = 4'd3,
    ADDR_CTRL    = 4'd4,
    ADDR_ID      = 4'd5,
    ADDR_STATUS  = 4'd6
  } cfg_addr_e;

  localparam int         CMD_WR_BIT = 7;
  localparam int         CMD_ADDR_W = 4;

  localparam logic [7:0] CFG_ID  = 8'h48;
  localparam logic [7:0] CFG_ACK = 8'hA5;

  localparam int STATUS_OVERRUN_BIT = 0;
  localparam int STATUS_TIMEOUT_BIT = 1;
  localparam int STATUS_W           = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_RESP  = 2'd2
  } cfg_state_e;

  // Out-of-range tap requests saturate to the last implemented tap rather
  // than aliasing onto a low tap through truncation.
  function automatic int unsigned clamp_tap(input logic [7:0] value,
                                            input int unsigned num_tap);
    if (32'(value) >= num_tap) return num_tap - 1;
    return 32'(value);
  endfunction

endpackage

// File: rtl/tthbif_cfg_regs.sv
// tthbif_cfg_regs
//   UART-byte command parser and configuration register file for the tthbif
//   lane. Write commands are two bytes (cmd with bit7=1, then data); read
//   commands are one byte and answered with one byte on the tx handshake.
//
//   Build option: define TTHBIF_CFG_ACK_EN to answer every completed write
//   with CFG_ACK (0xA5). Without it, writes are silent.
//
// Ports
//   clk_i              in   clock
//   rst_ni             in   asynchronous reset, active low
//   en_i               in   block enable; low forces IDLE and drops responses
//   rx_data_valid_i    in   one-cycle strobe, rx_data_i holds a byte
//   rx_data_i          in   received byte
//   tx_data_ready_i    in   UART tx can take a byte
//   tx_data_valid_o    out  response byte valid (held until ready)
//   tx_data_o          out  response byte
//   rx_flop_tap_sel_o  out  rx flop tap select to tthbif
//   rx_comb_tap_sel_o  out  rx comb tap select to tthbif
//   tx_flop_tap_sel_o  out  tx flop tap select to tthbif
//   tx_comb_tap_sel_o  out  tx comb tap select to tthbif
//   lane_en_o          out  CTRL.en gated by en_i (combinational)
//
// FSM states
//   state    | meaning
//   ST_IDLE  | waiting for a command byte
//   ST_WDATA | write command seen, waiting for its data byte (timed)
//   ST_RESP  | response byte presented, waiting for tx_data_ready_i
module tthbif_cfg_regs
  import tthbif_pkg::*;
#(
  parameter int NUM_FLOP_TAP = 4,
  parameter int NUM_COMB_TAP = 4,
  parameter int TIMEOUT_CLKS = 65536,
  localparam int FW = $clog2(NUM_FLOP_TAP),
  localparam int CW = $clog2(NUM_COMB_TAP)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          rx_data_valid_i,
  input  logic [7:0]    rx_data_i,
  input  logic          tx_data_ready_i,
  output logic          tx_data_valid_o,
  output logic [7:0]    tx_data_o,
  output logic [FW-1:0] rx_flop_tap_sel_o,
  output logic [CW-1:0] rx_comb_tap_sel_o,
  output logic [FW-1:0] tx_flop_tap_sel_o,
  output logic [CW-1:0] tx_comb_tap_sel_o,
  output logic          lane_en_o
);

  localparam int TW = $clog2(TIMEOUT_CLKS);

  cfg_state_e            state_q, state_d;
  logic [CMD_ADDR_W-1:0] addr_q, addr_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [FW-1:0]         rx_flop_q, rx_flop_d;
  logic [CW-1:0]         rx_comb_q, rx_comb_d;
  logic [FW-1:0]         tx_flop_q, tx_flop_d;
  logic [CW-1:0]         tx_comb_q, tx_comb_d;
  logic                  ctrl_en_q, ctrl_en_d;
  logic [STATUS_W-1:0]   status_q, status_d;
  logic [STATUS_W-1:0]   status_set, status_clr;
  logic [7:0]            rd_data;
  logic [FW-1:0]         wr_flop;
  logic [CW-1:0]         wr_comb;

  // Read data is decoded straight from the incoming command byte so the
  // response can be loaded on the same edge that accepts the read.
  always_comb begin
    rd_data = 8'h00;
    case (rx_data_i[CMD_ADDR_W-1:0])
      ADDR_RX_FLOP: rd_data = 8'(rx_flop_q);
      ADDR_RX_COMB: rd_data = 8'(rx_comb_q);
      ADDR_TX_FLOP: rd_data = 8'(tx_flop_q);
      ADDR_TX_COMB: rd_data = 8'(tx_comb_q);
      ADDR_CTRL:    rd_data = {7'b0, ctrl_en_q};
      ADDR_ID:      rd_data = CFG_ID;
      ADDR_STATUS:  rd_data = 8'(status_q);
      default:      rd_data = 8'h00;
    endcase
  end

  assign wr_flop = FW'(clamp_tap(rx_data_i, NUM_FLOP_TAP));
  assign wr_comb = CW'(clamp_tap(rx_data_i, NUM_COMB_TAP));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    rx_flop_d  = rx_flop_q;
    rx_comb_d  = rx_comb_q;
    tx_flop_d  = tx_flop_q;
    tx_comb_d  = tx_comb_q;
    ctrl_en_d  = ctrl_en_q;
    status_set = '0;
    status_clr = '0;

    if (!en_i) begin
      state_d    = ST_IDLE;
      tx_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data_valid_i) begin
            if (rx_data_i[CMD_WR_BIT]) begin
              state_d = ST_WDATA;
              addr_d  = rx_data_i[CMD_ADDR_W-1:0];
              cnt_d   = TW'(TIMEOUT_CLKS - 1);
            end else begin
              state_d    = ST_RESP;
              tx_valid_d = 1'b1;
              tx_data_d  = rd_data;
              if (rx_data_i[CMD_ADDR_W-1:0] == ADDR_STATUS) status_clr = '1;
            end
          end
        end

        ST_WDATA: begin
          if (rx_data_valid_i) begin
            case (addr_q)
              ADDR_RX_FLOP: rx_flop_d = wr_flop;
              ADDR_RX_COMB: rx_comb_d = wr_comb;
              ADDR_TX_FLOP: tx_flop_d = wr_flop;
              ADDR_TX_COMB: tx_comb_d = wr_comb;
              ADDR_CTRL:    ctrl_en_d = rx_data_i[0];
              default:      ;
            endcase
`ifdef TTHBIF_CFG_ACK_EN
            state_d    = ST_RESP;
            tx_valid_d = 1'b1;
            tx_data_d  = CFG_ACK;
`else
            state_d    = ST_IDLE;
`endif
          end else if (cnt_q == '0) begin
            state_d                        = ST_IDLE;
            status_set[STATUS_TIMEOUT_BIT] = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        ST_RESP: begin
          if (rx_data_valid_i) status_set[STATUS_OVERRUN_BIT] = 1'b1;
          if (tx_data_ready_i) begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A set event in the same cycle as a read-clear must survive.
  assign status_d = (status_q & ~status_clr) | status_set;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      rx_flop_q  <= '1;
      rx_comb_q  <= '1;
      tx_flop_q  <= '1;
      tx_comb_q  <= '1;
      ctrl_en_q  <= 1'b0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      rx_flop_q  <= rx_flop_d;
      rx_comb_q  <= rx_comb_d;
      tx_flop_q  <= tx_flop_d;
      tx_comb_q  <= tx_comb_d;
      ctrl_en_q  <= ctrl_en_d;
      status_q   <= status_d;
    end
  end

  assign tx_data_valid_o   = tx_valid_q;
  assign tx_data_o         = tx_data_q;
  assign rx_flop_tap_sel_o = rx_flop_q;
  assign rx_comb_tap_sel_o = rx_comb_q;
  assign tx_flop_tap_sel_o = tx_flop_q;
  assign tx_comb_tap_sel_o = tx_comb_q;
  assign lane_en_o         = ctrl_en_q & en_i;

endmodule

// File: tb/tb_tthbif_cfg_regs.sv
// Bench for tthbif_cfg_regs: expected response bytes are queued when a read
// (or acknowledged write) is issued and checked when the byte transfers.
module tb_tthbif_cfg_regs;
  import tthbif_pkg::*;

  localparam int TO = 64;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       en_i;
  logic       rx_data_valid_i;
  logic [7:0] rx_data_i;
  logic       tx_data_ready_i;
  logic       tx_data_valid_o;
  logic [7:0] tx_data_o;
  logic [1:0] rx_flop_tap_sel_o;
  logic [1:0] rx_comb_tap_sel_o;
  logic [1:0] tx_flop_tap_sel_o;
  logic [1:0] tx_comb_tap_sel_o;
  logic       lane_en_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  tthbif_cfg_regs #(
    .NUM_FLOP_TAP(4),
    .NUM_COMB_TAP(4),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .en_i             (en_i),
    .rx_data_valid_i  (rx_data_valid_i),
    .rx_data_i        (rx_data_i),
    .tx_data_ready_i  (tx_data_ready_i),
    .tx_data_valid_o  (tx_data_valid_o),
    .tx_data_o        (tx_data_o),
    .rx_flop_tap_sel_o(rx_flop_tap_sel_o),
    .rx_comb_tap_sel_o(rx_comb_tap_sel_o),
    .tx_flop_tap_sel_o(tx_flop_tap_sel_o),
    .tx_comb_tap_sel_o(tx_comb_tap_sel_o),
    .lane_en_o        (lane_en_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_i); #1;
    rx_data_valid_i = 1'b1;
    rx_data_i       = b;
    @(posedge clk_i); #1;
    rx_data_valid_i = 1'b0;
  endtask

  // Called right after the edge that accepted the command. Holds ready low
  // for 'delay' cycles, then performs one transfer and checks valid drops.
  task automatic collect_resp(input int delay, input string name);
    logic [7:0] exp;
    exp = (exp_q.size() != 0) ? exp_q[0] : 8'hxx;
    @(negedge clk_i);
    n_tests++;
    if (tx_data_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency: valid=%b required 1", name, tx_data_valid_o);
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk_i);
      n_tests++;
      if (tx_data_valid_o !== 1'b1 || tx_data_o !== exp) begin
        n_fail++;
        $display("FAIL %s hold[%0d]: valid=%b data=%02h required 1/%02h",
                 name, i, tx_data_valid_o, tx_data_o, exp);
      end
    end
    @(posedge clk_i); #1;
    tx_data_ready_i = 1'b1;
    @(negedge clk_i);
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    n_tests++;
    if (tx_data_valid_o !== 1'b1 || tx_data_o !== exp) begin
      n_fail++;
      $display("FAIL %s data: valid=%b data=%02h required 1/%02h",
               name, tx_data_valid_o, tx_data_o, exp);
    end
    @(posedge clk_i); #1;
    tx_data_ready_i = 1'b0;
    @(negedge clk_i);
    n_tests++;
    if (tx_data_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s single: valid=%b required 0", name, tx_data_valid_o);
    end
  endtask

  task automatic read_reg(input logic [3:0] addr, input logic [7:0] exp,
                          input int delay, input string name);
    exp_q.push_back(exp);
    send_byte({4'h0, addr});
    collect_resp(delay, name);
  endtask

  task automatic finish_write();
`ifdef TTHBIF_CFG_ACK_EN
    exp_q.push_back(CFG_ACK);
    collect_resp(0, "ack");
`endif
  endtask

  task automatic write_reg(input logic [3:0] addr, input logic [7:0] data);
    send_byte({4'h8, addr});
    send_byte(data);
    finish_write();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; en_i = 1'b1; rx_data_valid_i = 1'b0;
    rx_data_i = 8'h00; tx_data_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if ({rx_flop_tap_sel_o, rx_comb_tap_sel_o, tx_flop_tap_sel_o, tx_comb_tap_sel_o} !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_sel: got %b%b%b%b required all ones", rx_flop_tap_sel_o,
               rx_comb_tap_sel_o, tx_flop_tap_sel_o, tx_comb_tap_sel_o);
    end
    n_tests++;
    if (lane_en_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_lane_en: got %b required 0", lane_en_o);
    end
    n_tests++;
    if (tx_data_valid_o !== 1'b0 || tx_data_o !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_tx: valid=%b data=%02h required 0/00", tx_data_valid_o, tx_data_o);
    end
    read_reg(4'd6, 8'h00, 0, "reset_status");
  endtask

  task automatic test_write_read();
    write_reg(4'd1, 8'h02);
    n_tests++;
    if (rx_comb_tap_sel_o !== 2'd2) begin
      n_fail++; $display("FAIL wr_rx_comb: got %0d required 2", rx_comb_tap_sel_o);
    end
    read_reg(4'd1, 8'h02, 5, "rd_rx_comb");
    write_reg(4'd0, 8'h01);
    n_tests++;
    if (rx_flop_tap_sel_o !== 2'd1) begin
      n_fail++; $display("FAIL wr_rx_flop: got %0d required 1", rx_flop_tap_sel_o);
    end
    write_reg(4'd3, 8'h09);
    n_tests++;
    if (tx_comb_tap_sel_o !== 2'd3) begin
      n_fail++; $display("FAIL clamp_tx_comb: got %0d required 3", tx_comb_tap_sel_o);
    end
    write_reg(4'd2, 8'h00);
    n_tests++;
    if (tx_flop_tap_sel_o !== 2'd0) begin
      n_fail++; $display("FAIL wr_tx_flop: got %0d required 0", tx_flop_tap_sel_o);
    end
    read_reg(4'd5, 8'h48, 0, "rd_id");
    read_reg(4'd9, 8'h00, 1, "rd_unmapped");
    write_reg(4'd5, 8'h12);
    write_reg(4'd15, 8'h55);
    read_reg(4'd5, 8'h48, 0, "rd_id_after_wr");
    read_reg(4'd0, 8'h01, 0, "rd_rx_flop");
    read_reg(4'd3, 8'h03, 0, "rd_tx_comb");
  endtask

  task automatic test_lane_en();
    write_reg(4'd4, 8'h01);
    n_tests++;
    if (lane_en_o !== 1'b1) begin
      n_fail++; $display("FAIL lane_en_on: got %b required 1", lane_en_o);
    end
    en_i = 1'b0; #1;
    n_tests++;
    if (lane_en_o !== 1'b0) begin
      n_fail++; $display("FAIL lane_en_gate: got %b required 0", lane_en_o);
    end
    send_byte(8'h81);
    send_byte(8'h00);
    en_i = 1'b1; #1;
    n_tests++;
    if (lane_en_o !== 1'b1 || rx_comb_tap_sel_o !== 2'd2) begin
      n_fail++;
      $display("FAIL en_low_ignore: lane=%b rx_comb=%0d required 1/2", lane_en_o, rx_comb_tap_sel_o);
    end
    read_reg(4'd4, 8'h01, 0, "rd_ctrl");
  endtask

  task automatic test_timeout();
    send_byte(8'h80);
    repeat (TO + 6) @(posedge clk_i);
    @(negedge clk_i);
    n_tests++;
    if (rx_flop_tap_sel_o !== 2'd1 || tx_data_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_nowrite: rx_flop=%0d valid=%b required 1/0", rx_flop_tap_sel_o, tx_data_valid_o);
    end
    read_reg(4'd6, 8'h02, 0, "status_timeout");
    read_reg(4'd6, 8'h00, 0, "status_cleared");
    send_byte(8'h80);
    repeat (20) @(posedge clk_i);
    send_byte(8'h02);
    n_tests++;
    if (rx_flop_tap_sel_o !== 2'd2) begin
      n_fail++; $display("FAIL late_in_budget: got %0d required 2", rx_flop_tap_sel_o);
    end
    finish_write();
  endtask

  task automatic test_overrun();
    exp_q.push_back(8'h03);
    send_byte(8'h03);
    send_byte(8'h83);
    collect_resp(2, "overrun_resp");
    n_tests++;
    if (tx_comb_tap_sel_o !== 2'd3) begin
      n_fail++; $display("FAIL overrun_nowrite: got %0d required 3", tx_comb_tap_sel_o);
    end
    read_reg(4'd6, 8'h01, 0, "status_overrun");
    read_reg(4'd6, 8'h00, 0, "status_ovr_clr");
  endtask

  task automatic test_en_drop();
    send_byte(8'h05);
    @(posedge clk_i); #1;
    en_i = 1'b0;
    @(negedge clk_i);
    n_tests++;
    if (tx_data_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL en_drop_pre: valid=%b required 1", tx_data_valid_o);
    end
    @(posedge clk_i); #1;
    en_i = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if (tx_data_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL en_drop: valid=%b required 0", tx_data_valid_o);
    end
    read_reg(4'd1, 8'h02, 0, "after_en_drop");
  endtask

  task automatic test_reset_mid();
    send_byte(8'h81);
    #3 rst_ni = 1'b0;
    #1;
    n_tests++;
    if (rx_comb_tap_sel_o !== 2'd3 || lane_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: rx_comb=%0d lane=%b required 3/0", rx_comb_tap_sel_o, lane_en_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    read_reg(4'd1, 8'h03, 0, "reset_mid_idle");
  endtask

`ifdef TTHBIF_CFG_ACK_EN
  task automatic test_ack();
    write_reg(4'd2, 8'h07);
    n_tests++;
    if (tx_flop_tap_sel_o !== 2'd3) begin
      n_fail++; $display("FAIL ack_clamp: got %0d required 3", tx_flop_tap_sel_o);
    end
    send_byte(8'h82);
    send_byte(8'h01);
    @(negedge clk_i);
    n_tests++;
    if (tx_data_valid_o !== 1'b1 || tx_data_o !== CFG_ACK) begin
      n_fail++;
      $display("FAIL ack_present: valid=%b data=%02h required 1/a5", tx_data_valid_o, tx_data_o);
    end
    @(posedge clk_i); #1;
    en_i = 1'b0;
    @(posedge clk_i); #1;
    en_i = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if (tx_data_valid_o !== 1'b0 || tx_flop_tap_sel_o !== 2'd1) begin
      n_fail++;
      $display("FAIL ack_en_drop: valid=%b tx_flop=%0d required 0/1", tx_data_valid_o, tx_flop_tap_sel_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_lane_en();
    test_timeout();
    test_overrun();
    test_en_drop();
    test_reset_mid();
`ifdef TTHBIF_CFG_ACK_EN
    test_ack();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
